// File: rtl/biriscv_branch_arb.sv
// Serialises up to two resolved-branch reports per cycle into the single predictor training port.
// Optional same-cycle forwarding into an empty queue is enabled by BIRISCV_BRANCH_ARB_BYPASS_EN.
module biriscv_branch_arb #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              br0_valid_i,
    input  logic              br0_taken_i,
    input  logic [31:0]       br0_source_i,
    input  logic [31:0]       br0_pc_i,
    input  logic [2:0]        br0_kind_i,
    input  logic              br1_valid_i,
    input  logic              br1_taken_i,
    input  logic [31:0]       br1_source_i,
    input  logic [31:0]       br1_pc_i,
    input  logic [2:0]        br1_kind_i,
    output logic              upd_valid_o,
    output logic              upd_taken_o,
    output logic [31:0]       upd_source_o,
    output logic [31:0]       upd_pc_o,
    output logic [2:0]        upd_kind_o,
    input  logic              upd_accept_i,
    output logic              stall_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o
);
    localparam int              REC_W   = 68;
    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] L_STALL = (ADDR_W+1)'(DEPTH - 2);

    logic [REC_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic [REC_W-1:0]  w_rec0;
    logic [REC_W-1:0]  w_rec1;
    logic [REC_W-1:0]  w_head;
    logic [REC_W-1:0]  w_out;
    logic              w_empty;
    logic              w_bypass;
    logic              w_pop;
    logic              w_v0;
    logic              w_v1;
    logic              w_push0;
    logic              w_push1;
    logic              w_drop;
    logic [ADDR_W:0]   w_space;

    assign w_rec0  = {br0_taken_i, br0_kind_i, br0_source_i, br0_pc_i};
    assign w_rec1  = {br1_taken_i, br1_kind_i, br1_source_i, br1_pc_i};
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

`ifdef BIRISCV_BRANCH_ARB_BYPASS_EN
    assign w_bypass = w_empty && upd_accept_i && (br0_valid_i || br1_valid_i);
`else
    assign w_bypass = 1'b0;
`endif

    // The oldest valid report is the one forwarded; whatever remains is queued.
    assign w_pop   = !w_empty && upd_accept_i;
    assign w_v0    = br0_valid_i && !w_bypass;
    assign w_v1    = br1_valid_i && !(w_bypass && !br0_valid_i);

    // Free slots once this cycle's pop is credited; br0 claims a slot before br1.
    assign w_space = L_DEPTH - r_count + {{ADDR_W{1'b0}}, w_pop};
    assign w_push0 = w_v0 && (w_space != '0);
    assign w_push1 = w_v1 && (w_space > {{ADDR_W{1'b0}}, w_push0});
    assign w_drop  = (w_v0 && !w_push0) || (w_v1 && !w_push1);

    always_ff @(posedge clk_i) begin
        if (w_push0) begin
            r_mem[r_wr_ptr] <= w_rec0;
        end
        if (w_push1) begin
            r_mem[r_wr_ptr + ADDR_W'(w_push0)] <= w_rec1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(w_push0) + ADDR_W'(w_push1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count <= r_count + (ADDR_W+1)'(w_push0) + (ADDR_W+1)'(w_push1)
                       - (ADDR_W+1)'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Data is forced to zero whenever no record is presented, so stale storage never leaks out.
    always_comb begin
        w_out = '0;
        if (!w_empty) begin
            w_out = w_head;
        end else if (w_bypass) begin
            w_out = br0_valid_i ? w_rec0 : w_rec1;
        end
    end

    assign {upd_taken_o, upd_kind_o, upd_source_o, upd_pc_o} = w_out;
    assign upd_valid_o = !w_empty || w_bypass;
    assign stall_o     = (r_count > L_STALL);
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;

endmodule
